// File: rtl/data_mem_slave.sv
// data_mem_slave: 2^ADDR_W x 32-bit memory slave with a fixed number of wait
// cycles, byte-lane writes and lane-selected, right-justified reads.
//
// state | meaning
// IDLE  | waiting for memCe; the request is captured on the accepting edge
// WAIT  | counting down wait cycles on the captured copy of the request
// ACK   | access finished; memReady (and memErr/rdData) presented this cycle
module data_mem_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic        memRr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  output logic [31:0] rdData,
  output logic        memReady,
  output logic        memErr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic go_ack;

  logic              cap_wr, cap_rd, cap_hi;
  logic [ADDR_W-1:0] cap_idx;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_wmask, cap_rmask;

  logic              acc_wr, acc_rd, acc_hi;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wmask, acc_rmask;

  logic              addr_hi_in;
  logic              unused_addr_lsb;
  logic [31:0]       word_rd;
  logic [31:0]       rd_lane;
  logic              rmask_ok;
  logic              acc_err;
  logic              do_write, do_read;

  logic [31:0] mem [2**ADDR_W];

  assign addr_hi_in      = |(memAddr >> (ADDR_W + 2));
  assign unused_addr_lsb = ^memAddr[1:0];

  // With zero wait cycles the access happens on the accepting edge, so the
  // live inputs are used in IDLE and the captured copy everywhere else.
  assign acc_wr    = (state == ST_IDLE) ? memWr                : cap_wr;
  assign acc_rd    = (state == ST_IDLE) ? memRr                : cap_rd;
  assign acc_hi    = (state == ST_IDLE) ? addr_hi_in           : cap_hi;
  assign acc_idx   = (state == ST_IDLE) ? memAddr[ADDR_W+1:2]  : cap_idx;
  assign acc_wdata = (state == ST_IDLE) ? wtData               : cap_wdata;
  assign acc_wmask = (state == ST_IDLE) ? w_mask               : cap_wmask;
  assign acc_rmask = (state == ST_IDLE) ? r_mask               : cap_rmask;

  assign word_rd = mem[acc_idx];

  // Next-state logic; go_ack marks the edge that performs the access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_ack    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memCe) begin
          if (LATENCY == 0) begin
            state_nxt = ST_ACK;
            go_ack    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_ACK;
          go_ack    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read lane select: selected lanes right-justified, zero-extended.
  always_comb begin
    rmask_ok = 1'b1;
    rd_lane  = '0;
    case (acc_rmask)
      4'b0001: rd_lane = {24'd0, word_rd[7:0]};
      4'b0010: rd_lane = {24'd0, word_rd[15:8]};
      4'b0100: rd_lane = {24'd0, word_rd[23:16]};
      4'b1000: rd_lane = {24'd0, word_rd[31:24]};
      4'b0011: rd_lane = {16'd0, word_rd[15:0]};
      4'b1100: rd_lane = {16'd0, word_rd[31:16]};
      4'b1111: rd_lane = word_rd;
      default: rmask_ok = 1'b0;
    endcase
  end

  assign acc_err  = (acc_wr == acc_rd) | acc_hi | (acc_rd & ~rmask_ok);
  assign do_write = go_ack & rst & acc_wr & ~acc_err;
  assign do_read  = go_ack & acc_rd & ~acc_err;

  // Control state, captured request and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_rd    <= 1'b0;
      cap_hi    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_wmask <= '0;
      cap_rmask <= '0;
      rdData    <= '0;
      memReady  <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      memReady <= go_ack;
      memErr   <= go_ack & acc_err;
      if (state == ST_IDLE && memCe) begin
        cap_wr    <= memWr;
        cap_rd    <= memRr;
        cap_hi    <= addr_hi_in;
        cap_idx   <= memAddr[ADDR_W+1:2];
        cap_wdata <= wtData;
        cap_wmask <= w_mask;
        cap_rmask <= r_mask;
      end
      if (do_read) rdData <= rd_lane;
    end
  end

  // Memory array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: three instances (LATENCY 1/0/3) driven by
// directed and random requests, checked every cycle against a
// transaction-level memory model.
module tb_data_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [2:0]  ce = '0, wr = '0, rd = '0;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [3:0]  wm [3];
  logic [3:0]  rm [3];
  logic [31:0] rd_o [3];
  logic [2:0]  rdy, err;

  // model state
  logic [31:0] mm [3][1024];
  logic [31:0] exp_rd [3];
  bit          pend_v [3];
  int          pend_edge [3];
  int          nfree [3];
  bit          p_wr [3], p_rd [3];
  logic [31:0] p_addr [3], p_wd [3];
  logic [3:0]  p_wm [3], p_rm [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_slave #(.ADDR_W(10), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .memCe(ce[0]), .memWr(wr[0]), .memRr(rd[0]),
    .memAddr(addr[0]), .wtData(wdat[0]), .w_mask(wm[0]), .r_mask(rm[0]),
    .rdData(rd_o[0]), .memReady(rdy[0]), .memErr(err[0]));
  data_mem_slave #(.ADDR_W(4), .LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst), .memCe(ce[1]), .memWr(wr[1]), .memRr(rd[1]),
    .memAddr(addr[1]), .wtData(wdat[1]), .w_mask(wm[1]), .r_mask(rm[1]),
    .rdData(rd_o[1]), .memReady(rdy[1]), .memErr(err[1]));
  data_mem_slave #(.ADDR_W(4), .LATENCY(3)) u_dut2 (
    .clk(clk), .rst(rst), .memCe(ce[2]), .memWr(wr[2]), .memRr(rd[2]),
    .memAddr(addr[2]), .wtData(wdat[2]), .w_mask(wm[2]), .r_mask(rm[2]),
    .rdData(rd_o[2]), .memReady(rdy[2]), .memErr(err[2]));

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int aw_of(int k);
    return (k == 0) ? 10 : 4;
  endfunction

  function automatic bit legal_rm(logic [3:0] m);
    return (m == 4'h1) || (m == 4'h2) || (m == 4'h4) || (m == 4'h8) ||
           (m == 4'h3) || (m == 4'hC) || (m == 4'hF);
  endfunction

  // Lanes starting at the lowest selected byte, as many as are selected.
  function automatic logic [31:0] lanes(logic [31:0] w, logic [3:0] m);
    int lo, n;
    logic [63:0] keep;
    lo = 0; n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      if (n == 0) lo = i;
      n++;
    end
    keep = (64'd1 << (8 * n)) - 64'd1;
    return (w >> (8 * lo)) & keep[31:0];
  endfunction

  function automatic logic [31:0] pre_val(int k, int i);
    return 32'h5A00_0000 ^ (32'(k) << 16) ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model for one instance.
  task automatic check_inst(int k);
    logic er, ee;
    logic [31:0] bm;
    int idx;
    er = 1'b0; ee = 1'b0;
    if (!rst) begin
      pend_v[k] = 0;
      exp_rd[k] = '0;
    end else if (pend_v[k] && cyc == pend_edge[k]) begin
      pend_v[k] = 0;
      er = 1'b1;
      ee = (p_wr[k] == p_rd[k]) || ((p_addr[k] >> (aw_of(k) + 2)) != 0) ||
           (p_rd[k] && !legal_rm(p_rm[k]));
      if (!ee) begin
        idx = int'((p_addr[k] >> 2) & ((32'd1 << aw_of(k)) - 32'd1));
        if (p_wr[k]) begin
          bm = {{8{p_wm[k][3]}}, {8{p_wm[k][2]}}, {8{p_wm[k][1]}}, {8{p_wm[k][0]}}};
          mm[k][idx] = (mm[k][idx] & ~bm) | (p_wd[k] & bm);
        end else begin
          exp_rd[k] = lanes(mm[k][idx], p_rm[k]);
        end
      end
    end
    chk($sformatf("ready[%0d]", k), {31'd0, rdy[k]}, {31'd0, er});
    chk($sformatf("err[%0d]", k), {31'd0, err[k]}, {31'd0, ee});
    chk($sformatf("rdData[%0d]", k), rd_o[k], exp_rd[k]);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) check_inst(k);
  end

  task automatic scramble(int k);
    wr[k] = 1'($urandom); rd[k] = 1'($urandom);
    addr[k] = $urandom; wdat[k] = $urandom;
    wm[k] = 4'($urandom); rm[k] = 4'($urandom);
  endtask

  // Issue one request, hold it until memReady, return what was observed.
  task automatic req(input int k, input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] wmk, input logic [3:0] rmk,
                     input bit scr, output int acc, output int rdy_cyc,
                     output logic [31:0] got_rd, output logic got_err);
    bit seen;
    ce[k] = 1'b1; wr[k] = w; rd[k] = r; addr[k] = a; wdat[k] = d; wm[k] = wmk; rm[k] = rmk;
    acc = (cyc + 1 > nfree[k]) ? cyc + 1 : nfree[k];
    pend_v[k] = 1; pend_edge[k] = acc + lat_of(k);
    p_wr[k] = w; p_rd[k] = r; p_addr[k] = a; p_wd[k] = d; p_wm[k] = wmk; p_rm[k] = rmk;
    nfree[k] = acc + lat_of(k) + 2;
    seen = 0; rdy_cyc = -1; got_rd = '0; got_err = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        seen = 1; rdy_cyc = cyc; got_rd = rd_o[k]; got_err = err[k];
      end else if (scr && cyc >= acc) begin
        scramble(k);
      end
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL timeout[%0d]: no memReady within 40 cycles, expected at edge %0d", k, pend_edge[k]);
      pend_v[k] = 0;
    end
    #1;
    ce[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ce = '0;
    for (int k = 0; k < 3; k++) begin
      pend_v[k] = 0; nfree[k] = 0; exp_rd[k] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int acc, rc, prev_rc, c_acc, k, sel;
    logic [31:0] g, a, d;
    logic ge;
    logic [3:0] rmk;
    logic [3:0] legal [7];
    bit w, r;

    legal[0] = 4'h1; legal[1] = 4'h2; legal[2] = 4'h4; legal[3] = 4'h8;
    legal[4] = 4'h3; legal[5] = 4'hC; legal[6] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdat[i] = '0; wm[i] = '0; rm[i] = '0;
      exp_rd[i] = '0; pend_v[i] = 0; nfree[i] = 0; pend_edge[i] = 0;
    end

    #1 rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rdData[%0d]", i), rd_o[i], 32'h0);
      chk($sformatf("reset_ready[%0d]", i), {31'd0, rdy[i]}, 32'h0);
      chk($sformatf("reset_err[%0d]", i), {31'd0, err[i]}, 32'h0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // preload words 0..15 of every instance so the model knows the array
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++)
        req(i, 1, 0, 32'(j) << 2, pre_val(i, j), 4'hF, 4'h0, 0, acc, rc, g, ge);

    // full-word write and read, latency 1
    req(0, 1, 0, 32'h10, 32'h12345678, 4'hF, 4'h0, 0, acc, rc, g, ge);
    chk("wr_word_err", {31'd0, ge}, 32'h0);
    chk("wr_word_latency", 32'(rc - acc), 32'd1);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
    chk("rd_word_data", g, 32'h12345678);
    chk("rd_word_err", {31'd0, ge}, 32'h0);
    chk("rd_word_latency", 32'(rc - acc), 32'd1);

    // byte write and lane reads
    req(0, 1, 0, 32'h10, 32'hAAAAAAAA, 4'b0100, 4'h0, 0, acc, rc, g, ge);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
    chk("rd_after_byte_wr", g, 32'h12AA5678);
    req(0, 0, 1, 32'h13, 32'h0, 4'h0, 4'b1000, 0, acc, rc, g, ge);
    chk("rd_byte3", g, 32'h00000012);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'b1100, 0, acc, rc, g, ge);
    chk("rd_half_hi", g, 32'h000012AA);

    // error cases leave rdData and the array alone
    req(0, 1, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 4'hF, 0, acc, rc, g, ge);
    chk("err_wr_rd_flag", {31'd0, ge}, 32'h1);
    chk("err_wr_rd_rdData", g, 32'h000012AA);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'b0110, 0, acc, rc, g, ge);
    chk("err_rmask_flag", {31'd0, ge}, 32'h1);
    req(0, 1, 0, 32'h00001000, 32'hFFFFFFFF, 4'hF, 4'h0, 0, acc, rc, g, ge);
    chk("err_addr_flag", {31'd0, ge}, 32'h1);
    req(0, 0, 0, 32'h10, 32'hFFFFFFFF, 4'hF, 4'hF, 0, acc, rc, g, ge);
    chk("err_noop_flag", {31'd0, ge}, 32'h1);
    req(0, 0, 1, 32'h0, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
    chk("err_addr_no_alias", g, pre_val(0, 0));
    req(0, 1, 0, 32'h10, 32'h0, 4'h0, 4'h0, 0, acc, rc, g, ge);
    chk("wmask0_err", {31'd0, ge}, 32'h0);
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
    chk("wmask0_unchanged", g, 32'h12AA5678);

    // reset while a write waits: outputs clear at once, write is dropped
    c_acc = (cyc + 1 > nfree[0]) ? cyc + 1 : nfree[0];
    ce[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 32'h10;
    wdat[0] = 32'hDEADBEEF; wm[0] = 4'hF; rm[0] = 4'hF;
    for (int i = 0; i < 10 && cyc < c_acc; i++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    ce = '0;
    for (int i = 0; i < 3; i++) begin
      pend_v[i] = 0; nfree[i] = 0; exp_rd[i] = '0;
    end
    #1;
    chk("rst_wait_rdData", rd_o[0], 32'h0);
    chk("rst_wait_ready", {31'd0, rdy[0]}, 32'h0);
    chk("rst_wait_err", {31'd0, err[0]}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    req(0, 0, 1, 32'h10, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
    chk("rst_wait_dropped_wr", g, 32'h12AA5678);

    // latency 0: back-to-back accesses complete every second cycle
    for (int i = 0; i < 4; i++)
      req(1, 1, 0, 32'(i) << 2, 32'hA0B0C0D0 + 32'(i), 4'hF, 4'h0, 0, acc, rc, g, ge);
    prev_rc = -1;
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 1, 32'(i) << 2, 32'h0, 4'h0, 4'hF, 0, acc, rc, g, ge);
      chk($sformatf("lat0_rd%0d", i), g, 32'hA0B0C0D0 + 32'(i));
      chk($sformatf("lat0_latency%0d", i), 32'(rc - acc), 32'd0);
      if (prev_rc >= 0) chk($sformatf("lat0_spacing%0d", i), 32'(rc - prev_rc), 32'd2);
      prev_rc = rc;
    end

    // latency 3 with inputs scrambled during WAIT
    req(2, 1, 0, 32'h8, 32'hCAFEF00D, 4'hF, 4'h0, 1, acc, rc, g, ge);
    chk("lat3_latency", 32'(rc - acc), 32'd3);
    chk("lat3_wr_err", {31'd0, ge}, 32'h0);
    req(2, 0, 1, 32'h8, 32'h0, 4'h0, 4'hF, 1, acc, rc, g, ge);
    chk("lat3_rd_captured", g, 32'hCAFEF00D);

    // random traffic across all instances
    for (int n = 0; n < 600; n++) begin
      k = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 15));
      w = (sel == 0) || (sel >= 2 && sel <= 8);
      r = (sel == 0) || (sel >= 9);
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'd1 << $urandom_range(aw_of(k) + 2, 31));
      d = $urandom;
      rmk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 6)];
      req(k, w, r, a, d, 4'($urandom), rmk, 1'($urandom), acc, rc, g, ge);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_slave.md
DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 1, wait cycles inserted before response (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port memCe  input  1  request valid, held by master until memReady.
REQ-006 SHALL have port memWr  input  1  write request.
REQ-007 SHALL have port memRr  input  1  read request.
REQ-008 SHALL have port memAddr  input  32  byte address; word index = memAddr[ADDR_W+1:2], bits [1:0] ignored.
REQ-009 SHALL have port wtData  input  32  write data, lane-aligned.
REQ-010 SHALL have port w_mask  input  4  byte-lane write enables, bit i = bits [8i+7:8i].
REQ-011 SHALL have port r_mask  input  4  byte-lane read select.
REQ-012 SHALL have port rdData  output  32  registered read data.
REQ-013 SHALL have port memReady  output  1  one-cycle completion pulse.
REQ-014 SHALL have port memErr  output  1  error flag, valid with memReady.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, ACK; counter cnt[3:0].
REQ-016 IDLE: memCe=1 -> capture memWr, memRr, word index, upper address bits, wtData, w_mask, r_mask; go WAIT with cnt=LATENCY-1, or ACK directly if LATENCY=0.
REQ-017 WAIT: decrement cnt; cnt=0 -> ACK; input changes ignored (captured copy used).
REQ-018 ACK: perform access on captured request, memReady=1 this cycle only; next state IDLE.
REQ-019 Request accepted in cycle T SHALL see memReady in cycle T+1+LATENCY; throughput one access per LATENCY+2 cycles.
REQ-020 Write: for each i with w_mask[i]=1, word[8i+7:8i] <= wtData[8i+7:8i]; other lanes unchanged; w_mask=0000 completes with no change, memErr=0.
REQ-021 Read: selected lanes right-justified, zero-extended into rdData; legal r_mask 0001,0010,0100,1000 (byte), 0011,1100 (half), 1111 (word).
REQ-022 rdData SHALL update only in ACK of a successful read and hold until next successful read.
REQ-023 memErr=1 in ACK, no array write, rdData unchanged, when: memWr=memRr=1; memWr=memRr=0; illegal r_mask on read; memAddr[31:ADDR_W+2] nonzero.
REQ-024 memErr SHALL be 0 whenever memReady=0.
REQ-025 memCe=0 in IDLE SHALL leave all state unchanged.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, cnt=0, rdData=0, memReady=0, memErr=0.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 Reset during WAIT SHALL drop the pending request; a pending write SHALL NOT reach the array.
REQ-029 After rst release, first request accepted on first rising edge with memCe=1.

Verification
REQ-030 LATENCY=1: write 0x12345678 w_mask 1111 @0x10, then read r_mask 1111 @0x10 -> memReady 2 cycles after each accept, rdData=0x12345678, memErr=0.
REQ-031 Byte write 0xAAAAAAAA w_mask 0100 @0x10, read 1111 -> 0x12AA5678; read r_mask 1000 -> 0x00000012; read 1100 -> 0x000012AA.
REQ-032 Error cases: memWr=memRr=1; r_mask 0110; memAddr 0x00001000 (ADDR_W=10) -> memReady with memErr=1, rdData and array unchanged.
REQ-033 LATENCY=0 back-to-back reads held memCe=1 -> memReady every second cycle, correct data each.
REQ-034 Write accepted, rst=0 pulsed in WAIT -> outputs zero immediately, no memReady, later read of that word returns pre-write value.
REQ-035 Inputs changed during WAIT (LATENCY=3) -> access uses values captured at accept.
